mips_single_cycle: RTL and testbench

//  Top-level single-cycle MIPS32 subset processor: PC, instruction ROM, register file, ALU, data RAM.
//  - Every instruction completes in one clk cycle.
//  - Self-contained; no external buses.
//  - Runs a fixed built-in program; results are inspected hierarchically.

---
 rtl/mips_single_cycle.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_single_cycle.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : mips_single_cycle (with sub-module mips_regfile)
// Description : Single-cycle MIPS32 subset processor. Holds the PC, a built-in
//               instruction ROM, a 32x32 register file, the ALU and a data RAM.
//               Every instruction completes in one clk cycle.
//               Supported: add/sub/and/or/slt, addi, lw, sw, beq, j.
//               Every other encoding executes as a NOP.
// Ports       : clk   - single clock, all state updates on the rising edge
//               reset - synchronous active-high reset (PC and r1..r31 cleared,
//                       data RAM untouched)
// Parameters  : IMEM_WORDS - ROM depth in words, indexed by PC[7:2]
//               DMEM_WORDS - RAM depth in words, indexed by ALU result[7:2]
//               PROGRAM    - 0: summation program, 1: ALU/branch exercise
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// mips_regfile: 32 x 32-bit registers, two combinational read ports and one
// write port. r0 always reads as zero and ignores writes.
// ----------------------------------------------------------------------------
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            rf[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : rf[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : rf[i_ra2];
endmodule

module mips_single_cycle #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64,
    parameter int PROGRAM    = 0
) (
    input  logic clk,
    input  logic reset
);
    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_SLT = 3'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] w_rom [0:IMEM_WORDS-1];
    logic [31:0] w_instr, w_simm, w_pc_plus4, w_br_target;
    logic [31:0] w_rd1, w_rd2, w_alu_b, w_alu_result, w_mem_rdata, w_wb_data;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wa;
    logic [2:0]  w_alu_op;
    logic        w_reg_we, w_mem_we, w_mem_to_reg, w_alu_src_imm, w_branch, w_jump;
    logic [DMEM_AW-1:0] w_dmem_idx;
    logic [31:0] dmem [0:DMEM_WORDS-1];

    // Program ROM; unlisted words stay zero (sll r0 is unsupported -> NOP)
    always_comb begin
        for (int i = 0; i < IMEM_WORDS; i++) begin
            w_rom[i] = 32'd0;
        end
        if (PROGRAM == 0) begin
            w_rom[0] = 32'h2010_0005;   // addi $s0,$0,5
            w_rom[1] = 32'h2008_0000;   // addi $t0,$0,0
            w_rom[2] = 32'h1200_0003;   // beq  $s0,$0,+3
            w_rom[3] = 32'h0110_4020;   // add  $t0,$t0,$s0
            w_rom[4] = 32'h2210_FFFF;   // addi $s0,$s0,-1
            w_rom[5] = 32'h0800_0002;   // j    2
            w_rom[6] = 32'hAC08_0000;   // sw   $t0,0($0)
            w_rom[7] = 32'h8C11_0000;   // lw   $s1,0($0)
            w_rom[8] = 32'h0800_0008;   // j    8 (halt loop)
        end else begin
            w_rom[0]  = 32'h2000_0007;  // addi $0,$0,7      (discarded)
            w_rom[1]  = 32'h2009_0003;  // addi $9,$0,3
            w_rom[2]  = 32'h200A_0005;  // addi $10,$0,5
            w_rom[3]  = 32'h012A_5822;  // sub  $11,$9,$10
            w_rom[4]  = 32'h200C_FFFF;  // addi $12,$0,-1
            w_rom[5]  = 32'h200D_0001;  // addi $13,$0,1
            w_rom[6]  = 32'h018D_702A;  // slt  $14,$12,$13
            w_rom[7]  = 32'h2012_000C;  // addi $18,$0,12
            w_rom[8]  = 32'h2013_000A;  // addi $19,$0,10
            w_rom[9]  = 32'h0253_A024;  // and  $20,$18,$19
            w_rom[10] = 32'h0253_A825;  // or   $21,$18,$19
            w_rom[11] = 32'h112A_0005;  // beq  $9,$10,+5    (not taken)
            w_rom[12] = 32'h3418_0055;  // ori  $24,$0,0x55  (unsupported)
            w_rom[13] = 32'h016D_B820;  // add  $23,$11,$13
            w_rom[14] = 32'h1000_FFFF;  // beq  $0,$0,-1     (spin in place)
        end
    end

    assign w_instr = w_rom[pc_q[IMEM_AW+1:2]];
    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_funct = w_instr[5:0];
    assign w_simm  = {{16{w_instr[15]}}, w_instr[15:0]};

    // Main decoder
    always_comb begin
        w_reg_we      = 1'b0;
        w_wa          = w_rd;
        w_mem_we      = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src_imm = 1'b0;
        w_alu_op      = c_ALU_ADD;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_reg_we = 1'b1;
                case (w_funct)
                    6'h20:   w_alu_op = c_ALU_ADD;
                    6'h22:   w_alu_op = c_ALU_SUB;
                    6'h24:   w_alu_op = c_ALU_AND;
                    6'h25:   w_alu_op = c_ALU_OR;
                    6'h2A:   w_alu_op = c_ALU_SLT;
                    default: w_reg_we = 1'b0;
                endcase
            end
            c_OP_ADDI: begin
                w_reg_we      = 1'b1;
                w_wa          = w_rt;
                w_alu_src_imm = 1'b1;
            end
            c_OP_LW: begin
                w_reg_we      = 1'b1;
                w_wa          = w_rt;
                w_alu_src_imm = 1'b1;
                w_mem_to_reg  = 1'b1;
            end
            c_OP_SW: begin
                w_mem_we      = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            c_OP_BEQ: w_branch = 1'b1;
            c_OP_J:   w_jump   = 1'b1;
            default:  ;
        endcase
    end

    mips_regfile RF (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .i_we  (w_reg_we),
        .i_wa  (w_wa),
        .i_wd  (w_wb_data)
    );

    // ALU
    always_comb begin
        w_alu_b = w_alu_src_imm ? w_simm : w_rd2;
        case (w_alu_op)
            c_ALU_SUB: w_alu_result = w_rd1 - w_alu_b;
            c_ALU_AND: w_alu_result = w_rd1 & w_alu_b;
            c_ALU_OR:  w_alu_result = w_rd1 | w_alu_b;
            c_ALU_SLT: w_alu_result = {31'd0, $signed(w_rd1) < $signed(w_alu_b)};
            default:   w_alu_result = w_rd1 + w_alu_b;
        endcase
    end

    // Data RAM: not cleared by reset, but a store is suppressed while in reset
    assign w_dmem_idx  = w_alu_result[DMEM_AW+1:2];
    assign w_mem_rdata = dmem[w_dmem_idx];
    assign w_wb_data   = w_mem_to_reg ? w_mem_rdata : w_alu_result;

    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            dmem[w_dmem_idx] <= w_rd2;
        end
    end

    // Next PC
    assign w_pc_plus4  = pc_q + 32'd4;
    assign w_br_target = w_pc_plus4 + (w_simm << 2);

    always_comb begin
        pc_d = w_pc_plus4;
        if (w_jump) begin
            pc_d = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
        end else if (w_branch && (w_rd1 == w_rd2)) begin
            pc_d = w_br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_single_cycle
// Description : Self-checking bench for mips_single_cycle. Two instances run
//               the summation program and the ALU/branch program. An
//               instruction-level interpreter tracks both and is compared
//               with the architectural state after every clock edge, while
//               directed sequences and a vector table check the documented
//               results. The reset inputs are also toggled at random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_single_cycle;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mips_single_cycle #(.IMEM_WORDS(64), .DMEM_WORDS(64), .PROGRAM(0)) dut (
        .clk   (clk),
        .reset (rst0)
    );

    mips_single_cycle #(.IMEM_WORDS(64), .DMEM_WORDS(64), .PROGRAM(1)) dut_alu (
        .clk   (clk),
        .reset (rst1)
    );

    // ---------------- instruction-level reference model ----------------
    logic [31:0] prog   [2][64];
    logic [31:0] m_pc   [2];
    logic [31:0] m_rf   [2][32];
    logic [31:0] m_dmem [2][64];
    bit          m_dv   [2][64];

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int funct);
        return (rs << 21) | (rt << 16) | (rd << 11) | funct;
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return (op << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF);
    endfunction

    function automatic logic [31:0] enc_j(int target);
        return (2 << 26) | target;
    endfunction

    task automatic model_wr(int k, logic [4:0] r, logic [31:0] v);
        if (r != 5'd0) m_rf[k][r] = v;
    endtask

    task automatic model_step(int k, bit rst);
        logic [31:0] instr, a, b, simm, npc, addr;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  op, funct, idx;
        if (rst) begin
            m_pc[k] = 32'd0;
            for (int i = 0; i < 32; i++) m_rf[k][i] = 32'd0;
            return;
        end
        idx   = m_pc[k][7:2];
        instr = prog[k][idx];
        op    = instr[31:26];
        rs    = instr[25:21];
        rt    = instr[20:16];
        rd    = instr[15:11];
        funct = instr[5:0];
        simm  = {{16{instr[15]}}, instr[15:0]};
        a     = m_rf[k][rs];
        b     = m_rf[k][rt];
        npc   = m_pc[k] + 32'd4;
        addr  = a + simm;
        case (op)
            6'h00: case (funct)
                6'h20: model_wr(k, rd, a + b);
                6'h22: model_wr(k, rd, a - b);
                6'h24: model_wr(k, rd, a & b);
                6'h25: model_wr(k, rd, a | b);
                6'h2A: model_wr(k, rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            6'h08: model_wr(k, rt, addr);
            6'h23: model_wr(k, rt, m_dmem[k][addr[7:2]]);
            6'h2B: begin
                m_dmem[k][addr[7:2]] = b;
                m_dv[k][addr[7:2]]   = 1'b1;
            end
            6'h04: if (a == b) npc = npc + (simm << 2);
            6'h02: npc = {npc[31:28], instr[25:0], 2'b00};
            default: ;
        endcase
        m_pc[k] = npc;
    endtask

    // ---------------- DUT probes ----------------
    function automatic logic [31:0] get_rf(int k, logic [4:0] r);
        return (k == 0) ? dut.RF.rf[r] : dut_alu.RF.rf[r];
    endfunction

    function automatic logic [31:0] get_pc(int k);
        return (k == 0) ? dut.pc_q : dut_alu.pc_q;
    endfunction

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic cmp_model(int k);
        string       what;
        logic [31:0] got, want;
        bit          ok;
        ok = 1'b1;
        if (get_pc(k) !== m_pc[k]) begin
            ok = 1'b0; what = "pc"; got = get_pc(k); want = m_pc[k];
        end
        for (int i = 0; i < 32; i++) begin
            if (ok && get_rf(k, i[4:0]) !== m_rf[k][i]) begin
                ok = 1'b0; what = $sformatf("r%0d", i);
                got = get_rf(k, i[4:0]); want = m_rf[k][i];
            end
        end
        if (ok && k == 0 && m_dv[0][0] && dut.dmem[0] !== m_dmem[0][0]) begin
            ok = 1'b0; what = "dmem0"; got = dut.dmem[0]; want = m_dmem[0][0];
        end
        total++;
        if (ok) passed++;
        else $display("FAIL model_cmp prog%0d %s at t=%0t: got 0x%08h, expected 0x%08h",
                      k, what, $time, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst0);
        model_step(1, rst1);
        @(negedge clk);
        cmp_model(0);
        cmp_model(1);
    endtask

    task automatic check_final(string tag);
        check({tag, "_s0"},    dut.RF.rf[16], 32'd0);
        check({tag, "_t0"},    dut.RF.rf[8],  32'h0000_000F);
        check({tag, "_s1"},    dut.RF.rf[17], 32'd15);
        check({tag, "_dmem0"}, dut.dmem[0],   32'd15);
        check({tag, "_pc"},    dut.pc_q,      32'h20);
    endtask

    typedef struct {
        logic [4:0]  r;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t    vecs [10];
    logic [31:0] t0_exp [5];
    logic [31:0] t0_seen [$];
    logic [31:0] prev_t0, prev_pc;
    int          last_chg, done_cyc;
    bit          nt_seen, self_seen;

    initial begin
        // Vector table for the ALU/branch program: {register, expected value}
        vecs[0] = '{5'd0,  32'h0000_0000};   // write to r0 discarded
        vecs[1] = '{5'd9,  32'd3};
        vecs[2] = '{5'd10, 32'd5};
        vecs[3] = '{5'd11, 32'hFFFF_FFFE};   // 3 - 5
        vecs[4] = '{5'd12, 32'hFFFF_FFFF};
        vecs[5] = '{5'd14, 32'd1};           // -1 < 1 signed
        vecs[6] = '{5'd20, 32'h0000_0008};   // 0xC & 0xA
        vecs[7] = '{5'd21, 32'h0000_000E};   // 0xC | 0xA
        vecs[8] = '{5'd23, 32'hFFFF_FFFF};   // -2 + 1
        vecs[9] = '{5'd24, 32'd0};           // unsupported ori is a NOP
        t0_exp  = '{32'd5, 32'd9, 32'd12, 32'd14, 32'd15};

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                prog[k][i] = 32'd0; m_dmem[k][i] = 32'd0; m_dv[k][i] = 1'b0;
            end
            for (int i = 0; i < 32; i++) m_rf[k][i] = 32'd0;
            m_pc[k] = 32'd0;
        end
        prog[0][0] = enc_i(8, 0, 16, 5);
        prog[0][1] = enc_i(8, 0, 8, 0);
        prog[0][2] = enc_i(4, 16, 0, 3);
        prog[0][3] = enc_r(8, 16, 8, 32'h20);
        prog[0][4] = enc_i(8, 16, 16, -1);
        prog[0][5] = enc_j(2);
        prog[0][6] = enc_i(32'h2B, 0, 8, 0);
        prog[0][7] = enc_i(32'h23, 0, 17, 0);
        prog[0][8] = enc_j(8);
        prog[1][0]  = enc_i(8, 0, 0, 7);
        prog[1][1]  = enc_i(8, 0, 9, 3);
        prog[1][2]  = enc_i(8, 0, 10, 5);
        prog[1][3]  = enc_r(9, 10, 11, 32'h22);
        prog[1][4]  = enc_i(8, 0, 12, -1);
        prog[1][5]  = enc_i(8, 0, 13, 1);
        prog[1][6]  = enc_r(12, 13, 14, 32'h2A);
        prog[1][7]  = enc_i(8, 0, 18, 12);
        prog[1][8]  = enc_i(8, 0, 19, 10);
        prog[1][9]  = enc_r(18, 19, 20, 32'h24);
        prog[1][10] = enc_r(18, 19, 21, 32'h25);
        prog[1][11] = enc_i(4, 9, 10, 5);
        prog[1][12] = enc_i(32'h0D, 0, 24, 32'h55);
        prog[1][13] = enc_r(11, 13, 23, 32'h20);
        prog[1][14] = enc_i(4, 0, 0, -1);

        // ---- reset state ----
        rst0 = 1'b1; rst1 = 1'b1;
        tick();
        check("reset_pc", dut.pc_q, 32'd0);
        check("reset_t0", dut.RF.rf[8], 32'd0);

        // ---- run both programs 50 cycles, trace t0 and the ALU program PC ----
        rst0 = 1'b0; rst1 = 1'b0;
        prev_t0 = dut.RF.rf[8]; prev_pc = dut_alu.pc_q;
        last_chg = 0; done_cyc = 0; nt_seen = 1'b0; self_seen = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (dut.RF.rf[8] !== prev_t0) begin
                t0_seen.push_back(dut.RF.rf[8]);
                last_chg = c;
            end
            prev_t0 = dut.RF.rf[8];
            if (done_cyc == 0 && dut.RF.rf[16] == 0 && dut.RF.rf[8] == 15 &&
                dut.RF.rf[17] == 15 && dut.pc_q == 32'h20) done_cyc = c;
            if (prev_pc == 32'h2C && dut_alu.pc_q == 32'h30) nt_seen = 1'b1;
            if (prev_pc == 32'h38 && dut_alu.pc_q == 32'h38) self_seen = 1'b1;
            prev_pc = dut_alu.pc_q;
        end
        check("t0_change_count", t0_seen.size(), 32'd5);
        for (int i = 0; i < 5 && i < t0_seen.size(); i++)
            check($sformatf("t0_step%0d", i), t0_seen[i], t0_exp[i]);
        check("t0_last_change_cycle", last_chg, 32'd20);
        check("final_state_cycle", done_cyc, 32'd25);
        check_final("run1");

        for (int i = 0; i < 10; i++)
            check($sformatf("alu_r%0d", vecs[i].r), dut_alu.RF.rf[vecs[i].r], vecs[i].exp);
        check("beq_not_taken_pc4", {31'd0, nt_seen}, 32'd1);
        check("beq_self_loop", {31'd0, self_seen}, 32'd1);
        check("beq_self_pc", dut_alu.pc_q, 32'h38);

        // ---- reset for one cycle at cycle 10, then rerun ----
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        rst0 = 1'b1; tick();
        check("midreset_pc", dut.pc_q, 32'd0);
        check("midreset_t0", dut.RF.rf[8], 32'd0);
        check("midreset_s0", dut.RF.rf[16], 32'd0);
        check("midreset_s1", dut.RF.rf[17], 32'd0);
        check("midreset_dmem_kept", dut.dmem[0], 32'd15);
        rst0 = 1'b0;
        for (int c = 0; c < 50; c++) tick();
        check_final("rerun");

        // ---- random reset pulses on both instances against the model ----
        for (int c = 0; c < 400; c++) begin
            rst0 = ($urandom_range(0, 9) == 0);
            rst1 = ($urandom_range(0, 9) == 0);
            tick();
        end
        rst0 = 1'b1; rst1 = 1'b0; tick();
        rst0 = 1'b0;
        for (int c = 0; c < 50; c++) tick();
        check_final("after_random");
        check("after_random_alu_pc", dut_alu.pc_q, 32'h38);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
